core_memory: RTL and testbench
==============================

CORE_MEMORY -- requirements
Module: core_memory

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 1024, byte capacity of RAM; power of two, at least 4.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port address  input  32  byte address driven by core.
REQ-005 SHALL have port wr_data  input  32  write data from core.
REQ-006 SHALL have port write_enable  input  1  core write strobe, one cycle per store.
REQ-007 SHALL have port rd_data  output  32  read data to core.
REQ-008 SHALL have port load_valid  input  1  loader byte valid.
REQ-009 SHALL have port load_byte  input  8  loader byte.
REQ-010 SHALL have port load_ready  output  1  loader can accept byte.
REQ-011 SHALL have port core_rst  output  1  holds core in reset while loading.
REQ-012 SHALL have port mmio_out  output  8  memory-mapped output register.

Function
REQ-013 SHALL store DEPTH_BYTES bytes; effective byte index = address mod DEPTH_BYTES.
REQ-014 SHALL drive rd_data combinationally, little-endian: rd_data[8k+7:8k] = RAM[(address+k) mod DEPTH_BYTES], k=0..3, so unaligned fetch at any byte works.
REQ-015 SHALL on rising edge with write_enable=1 and FSM in RUN write wr_data bytes 0..3 to RAM[(address+k) mod DEPTH_BYTES]; index wraps past top.
REQ-016 SHALL ignore write_enable outside RUN.
REQ-017 SHALL make a write visible on rd_data in the cycle after the write edge; same-cycle rd_data shows old contents.
REQ-018 SHALL implement loader FSM states LEN_LO, LEN_HI, DATA, RUN.
REQ-019 SHALL assert load_ready=1 in LEN_LO, LEN_HI, DATA; 0 in RUN.
REQ-020 SHALL accept a byte when load_valid=1 and load_ready=1 at a rising edge; no accept otherwise, state held.
REQ-021 LEN_LO: accepted byte -> length[7:0], go LEN_HI.
REQ-022 LEN_HI: accepted byte -> length[15:8]; go RUN if full 16-bit length is 0, else DATA with pointer=0, count=0.
REQ-023 DATA: accepted byte -> RAM[pointer mod DEPTH_BYTES], pointer+1, count+1; go RUN on the accept where count+1 == length.
REQ-024 SHALL drive core_rst=1 in LEN_LO, LEN_HI, DATA; core_rst=0 only in RUN, registered, changing on the edge entering RUN.
REQ-025 RUN is terminal until rst; load_valid ignored.
REQ-026 Length greater than DEPTH_BYTES SHALL wrap pointer and overwrite earlier bytes; no error.

Reset
REQ-027 rst=1 SHALL immediately force FSM=LEN_LO, core_rst=1, load_ready=1, length=0, pointer=0, count=0, mmio_out=0.
REQ-028 RAM contents SHALL NOT be cleared by rst; reset mid-load restarts protocol at LEN_LO, previously loaded bytes retained.

Configuration
REQ-029 Macro CORE_MEMORY_MMIO_EN defined: address 0xFFFF_FFF0 is MMIO; RUN write there sets mmio_out=wr_data[7:0] and RAM unchanged; read there gives rd_data={24'b0, mmio_out}.
REQ-030 CORE_MEMORY_MMIO_EN undefined: mmio_out tied 0; 0xFFFF_FFF0 treated as ordinary RAM address per REQ-013.

Verification
REQ-031 Load 03 00 AA BB CC, then idle -> core_rst falls on edge after 5th accept; load_ready=0; address=0 gives rd_data=0x??CCBBAA, byte 3 untouched.
REQ-032 Load 00 00 -> RUN after 2nd accept; no RAM byte changed; core_rst=0.
REQ-033 RUN, DEPTH_BYTES=1024, write 0x11223344 at address 0x3FE -> RAM[0x3FE]=44, [0x3FF]=33, [0x000]=22, [0x001]=11; read at 0x3FE returns 0x11223344.
REQ-034 load_valid toggling 1,0,1 during DATA -> only cycles with load_valid=1 accept; pointer advances exactly per accept.
REQ-035 rst pulse after 2 of 4 DATA bytes -> LEN_LO, core_rst=1, earlier 2 bytes still readable; fresh header restarts load at pointer 0.
REQ-036 With CORE_MEMORY_MMIO_EN, RUN write 0x000000A5 to 0xFFFF_FFF0 -> mmio_out=0xA5 next cycle, rd_data=0x000000A5 at that address; without macro mmio_out stays 0 and RAM[0x3F0..0x3F3] = A5 00 00 00.

Source files
------------

// File: rtl/core_memory.sv
// rtl/core_memory.sv - byte-addressed core RAM with serial boot loader and optional MMIO output register
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   address           core byte address; RAM index is address mod DEPTH_BYTES
//   wr_data           core store data, written little-endian to 4 consecutive bytes
//   write_enable      core store strobe, honoured only after the load completes
//   rd_data           combinational little-endian 32-bit read at any byte alignment
//   load_valid        loader byte strobe
//   load_byte         loader byte: length low, length high, then payload bytes
//   load_ready        loader may present a byte (high until the load completes)
//   core_rst          holds the core in reset until the load completes
//   mmio_out          output register at 0xFFFF_FFF0 (present only with CORE_MEMORY_MMIO_EN)
//
// Build option: define CORE_MEMORY_MMIO_EN to map 0xFFFF_FFF0 to mmio_out instead of RAM.

module core_memory #(
  parameter int unsigned DEPTH_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  input  logic        write_enable,
  output logic [31:0] rd_data,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  output logic        load_ready,
  output logic        core_rst,
  output logic [7:0]  mmio_out
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {LEN_LO, LEN_HI, DATA, RUN} state_e;

  state_e      state_q, state_d;
  logic [15:0] length_q, length_d;
  logic [15:0] pointer_q, pointer_d;
  logic [15:0] count_q, count_d;
  logic        load_ready_q, load_ready_d;
  logic        core_rst_q, core_rst_d;

  logic [7:0]    mem_q [DEPTH_BYTES];
  logic [AW-1:0] base_idx;
  logic [AW-1:0] ptr_idx;
  logic          accept;
  logic          is_mmio;
  logic          core_we;
  logic          load_we;
  logic          unused_addr;

  // Only the low AW address bits select a byte; the rest alias.
  assign base_idx    = address[AW-1:0];
  assign ptr_idx     = AW'({16'b0, pointer_q});
  assign unused_addr = ^address[31:AW];

`ifdef CORE_MEMORY_MMIO_EN
  logic [7:0] mmio_q, mmio_d;
  assign is_mmio  = (address == 32'hFFFF_FFF0);
  assign mmio_out = mmio_q;
`else
  assign is_mmio  = 1'b0;
  assign mmio_out = 8'h00;
`endif

  assign accept  = load_valid && (state_q != RUN);
  assign core_we = write_enable && (state_q == RUN) && !is_mmio;
  assign load_we = accept && (state_q == DATA);

  assign load_ready = load_ready_q;
  assign core_rst   = core_rst_q;

  always_comb begin
    state_d   = state_q;
    length_d  = length_q;
    pointer_d = pointer_q;
    count_d   = count_q;
    case (state_q)
      LEN_LO: begin
        if (accept) begin
          length_d = {length_q[15:8], load_byte};
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          length_d  = {load_byte, length_q[7:0]};
          pointer_d = 16'd0;
          count_d   = 16'd0;
          // A zero-length image boots straight into RUN.
          state_d   = ({load_byte, length_q[7:0]} == 16'd0) ? RUN : DATA;
        end
      end
      DATA: begin
        if (accept) begin
          pointer_d = pointer_q + 16'd1;
          count_d   = count_q + 16'd1;
          if (count_q + 16'd1 == length_q) state_d = RUN;
        end
      end
      default: state_d = state_q;
    endcase
    // Outputs are registered from the next state so they switch on the edge entering RUN.
    load_ready_d = (state_d != RUN);
    core_rst_d   = (state_d != RUN);
  end

`ifdef CORE_MEMORY_MMIO_EN
  always_comb begin
    mmio_d = mmio_q;
    if (write_enable && (state_q == RUN) && is_mmio) mmio_d = wr_data[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mmio_q <= 8'h00;
    else     mmio_q <= mmio_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LEN_LO;
      length_q     <= 16'd0;
      pointer_q    <= 16'd0;
      count_q      <= 16'd0;
      load_ready_q <= 1'b1;
      core_rst_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      length_q     <= length_d;
      pointer_q    <= pointer_d;
      count_q      <= count_d;
      load_ready_q <= load_ready_d;
      core_rst_q   <= core_rst_d;
    end
  end

  // RAM survives reset so a reset mid-load keeps already loaded bytes.
  // Core and loader writes never coincide: one needs RUN, the other DATA.
  always_ff @(posedge clk) begin
    if (core_we) begin
      for (int k = 0; k < 4; k++) mem_q[base_idx + AW'(k)] <= wr_data[8*k +: 8];
    end else if (load_we) begin
      mem_q[ptr_idx] <= load_byte;
    end
  end

  always_comb begin
    rd_data = 32'h0;
    for (int k = 0; k < 4; k++) rd_data[8*k +: 8] = mem_q[base_idx + AW'(k)];
`ifdef CORE_MEMORY_MMIO_EN
    if (is_mmio) rd_data = {24'h0, mmio_q};
`endif
  end

endmodule

// File: tb/tb_core_memory.sv
// tb/tb_core_memory.sv - randomized self-checking bench for core_memory against a byte-array reference model

module tb_core_memory;

  localparam int D = 1024;
`ifdef CORE_MEMORY_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic        write_enable;
  logic [31:0] rd_data;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_ready;
  logic        core_rst;
  logic [7:0]  mmio_out;

  core_memory #(.DEPTH_BYTES(D)) dut (
    .clk(clk), .rst(rst), .address(address), .wr_data(wr_data),
    .write_enable(write_enable), .rd_data(rd_data), .load_valid(load_valid),
    .load_byte(load_byte), .load_ready(load_ready), .core_rst(core_rst),
    .mmio_out(mmio_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the boot protocol as "header bytes seen / payload bytes seen / running".
  byte unsigned m_mem [D];
  bit           m_known [D];
  int           m_hdr;
  int           m_len;
  int           m_loaded;
  bit           m_run;
  logic [7:0]   m_mmio;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ram_idx(input logic [31:0] a, input int k);
    return int'((a + 32'(k)) & 32'(D - 1));
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = m_mem[ram_idx(a, k)];
    if (MMIO && a == 32'hFFFF_FFF0) r = {24'h0, m_mmio};
    return r;
  endfunction

  function automatic logic [31:0] exp_mask(input logic [31:0] a);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = m_known[ram_idx(a, k)] ? 8'hFF : 8'h00;
    if (MMIO && a == 32'hFFFF_FFF0) m = 32'hFFFF_FFFF;
    return m;
  endfunction

  task automatic model_reset();
    m_hdr = 0; m_len = 0; m_loaded = 0; m_run = 1'b0; m_mmio = 8'h00;
  endtask

  task automatic model_edge();
    if (!m_run) begin
      if (load_valid) begin
        if (m_hdr == 0) begin
          m_len = int'(load_byte); m_hdr = 1;
        end else if (m_hdr == 1) begin
          m_len = m_len + int'(load_byte) * 256; m_hdr = 2; m_loaded = 0;
          if (m_len == 0) m_run = 1'b1;
        end else begin
          m_mem[m_loaded % D] = load_byte; m_known[m_loaded % D] = 1'b1;
          m_loaded++;
          if (m_loaded == m_len) m_run = 1'b1;
        end
      end
    end else if (write_enable) begin
      if (MMIO && address == 32'hFFFF_FFF0) m_mmio = wr_data[7:0];
      else for (int k = 0; k < 4; k++) begin
        m_mem[ram_idx(address, k)] = wr_data[8*k +: 8];
        m_known[ram_idx(address, k)] = 1'b1;
      end
    end
  endtask

  // One clock: check pre-edge read (old contents), advance model, check post-edge outputs.
  task automatic tick();
    logic [31:0] m;
    @(negedge clk);
    m = exp_mask(address);
    if (m != 32'h0) check("rd_pre", rd_data & m, exp_rd(address) & m);
    model_edge();
    @(posedge clk);
    #1;
    check("core_rst", core_rst, !m_run);
    check("load_ready", load_ready, !m_run);
    check("mmio_out", mmio_out, m_mmio);
    m = exp_mask(address);
    if (m != 32'h0) check("rd_post", rd_data & m, exp_rd(address) & m);
  endtask

  task automatic send(input logic [7:0] b);
    load_valid = 1'b1; load_byte = b;
    tick();
    load_valid = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    check("rst_core_rst", core_rst, 1'b1);
    check("rst_load_ready", load_ready, 1'b1);
    check("rst_mmio", mmio_out, 8'h00);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int cycles;
    logic [7:0] b0, b1;
    rst = 1'b1; address = 32'h0; wr_data = 32'h0; write_enable = 1'b0;
    load_valid = 1'b0; load_byte = 8'h00;
    for (int i = 0; i < D; i++) begin m_mem[i] = 8'h00; m_known[i] = 1'b0; end
    model_reset();
    #2;
    check("reset_core_rst", core_rst, 1'b1);
    check("reset_load_ready", load_ready, 1'b1);
    check("reset_mmio", mmio_out, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Oversized image (1030 bytes) wraps and overwrites the first 6; random valid gaps.
    send(8'h06); send(8'h04);
    cycles = 0;
    while (!m_run && cycles < 6000) begin
      load_valid = ($urandom_range(3) != 0);
      load_byte  = 8'($urandom);
      address    = $urandom;
      tick();
      cycles++;
    end
    load_valid = 1'b0;
    check("image_core_rst", core_rst, 1'b0);

    // Random reads in RUN; loader traffic must be ignored.
    for (int i = 0; i < 100; i++) begin
      address = $urandom; load_valid = $urandom_range(1); load_byte = 8'($urandom);
      tick();
    end
    load_valid = 1'b0;

    // Store wrapping past the top of RAM.
    address = 32'h3FE; wr_data = 32'h1122_3344; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    tick();
    check("wrap_word", rd_data, 32'h1122_3344);
    address = 32'h0;
    #1 check("wrap_low", {16'h0, rd_data[15:0]}, 32'h0000_1122);

    // Random mixed stores and reads.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(3))
        0: address = $urandom_range(D - 1);
        1: address = 32'(D - 3 + $urandom_range(2)) + 32'(D * $urandom_range(7));
        2: address = 32'hFFFF_FFF0;
        default: address = $urandom;
      endcase
      wr_data = $urandom; write_enable = $urandom_range(1);
      tick();
    end
    write_enable = 1'b0;

    // MMIO register, or ordinary RAM alias at 0x3F0 without it.
    address = 32'hFFFF_FFF0; wr_data = 32'h0000_00A5; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
`ifdef CORE_MEMORY_MMIO_EN
    check("mmio_reg", mmio_out, 8'hA5);
    check("mmio_rd", rd_data, 32'h0000_00A5);
`else
    check("mmio_tied", mmio_out, 8'h00);
    address = 32'h3F0;
    #1 check("mmio_alias", rd_data, 32'h0000_00A5);
`endif

    // Zero-length image: RUN right after the header, RAM untouched.
    rst_pulse();
    send(8'h00);
    check("zero_hdr_ready", load_ready, 1'b1);
    send(8'h00);
    check("zero_len_run", core_rst, 1'b0);
    for (int i = 0; i < 20; i++) begin address = $urandom; tick(); end

    // Short image 03 00 AA BB CC.
    rst_pulse();
    send(8'h03); send(8'h00); send(8'hAA); send(8'hBB);
    check("short_still_rst", core_rst, 1'b1);
    send(8'hCC);
    check("short_run", core_rst, 1'b0);
    check("short_ready", load_ready, 1'b0);
    address = 32'h0;
    tick();
    check("short_bytes", {8'h00, rd_data[23:0]}, 32'h00CC_BBAA);
    check("short_byte3", {24'h0, rd_data[31:24]}, {24'h0, m_mem[3]});

    // Reset part-way through the payload, then a fresh load from pointer 0.
    rst_pulse();
    b0 = 8'($urandom); b1 = 8'($urandom);
    send(8'h04); send(8'h00); send(b0); send(b1);
    rst_pulse();
    address = 32'h0;
    #1 check("kept_bytes", {16'h0, rd_data[15:0]}, {16'h0, b1, b0});
    send(8'h02); send(8'h00); send(8'h33);
    load_valid = 1'b0;
    tick();
    send(8'h44);
    check("reload_bytes", {16'h0, rd_data[15:0]}, 32'h0000_4433);
    check("reload_run", core_rst, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
